// File: rtl/serial_mem_receiver_pkg.sv
// Shared constants and state encoding for the serial memory receiver.
//   DATA_W : bits per byte / memory word
//   DEPTH  : number of memory locations
//   ADDR_W : address width, clog2(DEPTH)
//   state_t: receiver FSM states
package serial_mem_receiver_pkg;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2
    } state_t;
endpackage

// File: rtl/serial_mem_receiver_if.sv
// Bus bundle for the serial memory receiver.
//   master: drives bit_in, bit_valid and rd_addr; observes the status and read data.
//   slave : the receiver side, which sees the serial stream and read address
//           and returns rd_data, wr_addr, bit_count, last_byte, byte_done,
//           mem_full and overflow.
interface serial_mem_receiver_if;
    import serial_mem_receiver_pkg::*;

    logic              bit_in;
    logic              bit_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        bit_count;
    logic [DATA_W-1:0] last_byte;
    logic              byte_done;
    logic              mem_full;
    logic              overflow;

    modport master (
        output bit_in, bit_valid, rd_addr,
        input  rd_data, wr_addr, bit_count, last_byte, byte_done, mem_full, overflow
    );

    modport slave (
        input  bit_in, bit_valid, rd_addr,
        output rd_data, wr_addr, bit_count, last_byte, byte_done, mem_full, overflow
    );
endinterface

// File: rtl/serial_mem_receiver_sync_ram_16x8.sv
// DEPTH x DATA_W byte store: synchronous write, asynchronous read.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : mem[raddr], combinational
// The array has no reset; contents survive a receiver clear.
module sync_ram_16x8
    import serial_mem_receiver_pkg::*;
(
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-during-write returns the old word until the edge commits.
    assign rdata = mem[raddr];
endmodule

// File: rtl/serial_mem_receiver.sv
// Serial-to-parallel receiver that fills a DEPTH x DATA_W store from an
// LSB-first bit stream, one byte per DATA_W accepted bits.
//   clock : system clock, rising edge
//   clear : synchronous active-high reset, overrides all other inputs
//   bus   : slave side of serial_mem_receiver_if
//           (bit_in/bit_valid stream, rd_addr/rd_data inspection port,
//            wr_addr, bit_count, last_byte, byte_done, mem_full, overflow)
module serial_mem_receiver
    import serial_mem_receiver_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    serial_mem_receiver_if.slave  bus
);
    state_t            state, state_next;
    logic [DATA_W-1:0] sr;
    logic [2:0]        bit_count;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] last_byte;
    logic              byte_done;
    logic              overflow;

    logic              accept;
    logic              complete;
    logic              overflow_set;
    logic [DATA_W-1:0] sr_next;

    // New bit enters at the top, so the k-th received bit lands at bit k.
    assign sr_next = {bus.bit_in, sr[DATA_W-1:1]};

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        complete     = 1'b0;
        overflow_set = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bit_valid) begin
                    accept     = 1'b1;
                    state_next = RECV;
                end
            end
            RECV: begin
                if (bus.bit_valid) begin
                    accept = 1'b1;
                    if (bit_count == 3'd7) begin
                        complete = 1'b1;
                        if (wr_addr == ADDR_W'(DEPTH - 1)) begin
                            state_next = FULL;
                        end
                    end
                end
            end
            FULL: begin
                // Stream is dropped; only flag that data was lost.
                overflow_set = bus.bit_valid;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            sr        <= '0;
            bit_count <= '0;
            wr_addr   <= '0;
            last_byte <= '0;
            byte_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            byte_done <= complete;
            if (accept) begin
                sr        <= sr_next;
                bit_count <= bit_count + 3'd1;
            end
            if (complete) begin
                last_byte <= sr_next;
                // Wraps to 0 on the last location, which is also the FULL value.
                wr_addr   <= wr_addr + ADDR_W'(1);
            end
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    sync_ram_16x8 u_ram (
        .clock (clock),
        .we    (complete && !clear),
        .waddr (wr_addr),
        .wdata (sr_next),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

    assign bus.wr_addr   = wr_addr;
    assign bus.bit_count = bit_count;
    assign bus.last_byte = last_byte;
    assign bus.byte_done = byte_done;
    assign bus.mem_full  = (state == FULL);
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_serial_mem_receiver.sv
module tb_serial_mem_receiver;
    import serial_mem_receiver_pkg::*;

    logic clk = 1'b0;
    logic clear;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   doubles = 0;
    logic prev_done = 1'b0;
    int   p0;

    serial_mem_receiver_if bus ();

    serial_mem_receiver dut (
        .clock (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Count byte_done pulses and any back-to-back high cycles.
    always @(negedge clk) begin
        if (bus.byte_done) pulses++;
        if (bus.byte_done && prev_done) doubles++;
        prev_done = bus.byte_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input int n);
        clear = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
        bus.rd_addr = a;
        #1;
        chk(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] v;
        clear         = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.rd_addr   = '0;
        #2;

        // Reset state
        do_clear(2);
        chk("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
        chk("rst_bit_count", 32'(bus.bit_count), 32'd0);
        chk("rst_last_byte", 32'(bus.last_byte), 32'd0);
        chk("rst_byte_done", 32'(bus.byte_done), 32'd0);
        chk("rst_mem_full",  32'(bus.mem_full),  32'd0);
        chk("rst_overflow",  32'(bus.overflow),  32'd0);

        // 1: single byte 0xCC
        p0 = pulses;
        for (int i = 0; i < 7; i++) send_bit(i[1] ? 1'b1 : 1'b0);
        chk("t1_bc7", 32'(bus.bit_count), 32'd7);
        chk("t1_no_done_early", 32'(bus.byte_done), 32'd0);
        send_bit(1'b1);
        chk("t1_byte_done", 32'(bus.byte_done), 32'd1);
        chk("t1_wr_addr",   32'(bus.wr_addr),   32'd1);
        chk("t1_last_byte", 32'(bus.last_byte), 32'hCC);
        chk("t1_bit_count", 32'(bus.bit_count), 32'd0);
        rd(4'd0, 8'hCC, "t1_rd0");
        idle(1);
        chk("t1_done_drop", 32'(bus.byte_done), 32'd0);
        chk("t1_pulses", 32'(pulses - p0), 32'd1);

        // 2: fill all 16 locations, then overflow
        do_clear(1);
        for (int i = 0; i < 15; i++) send_byte(i[0] ? 8'hAA : 8'hCC);
        chk("t2_not_full_yet", 32'(bus.mem_full), 32'd0);
        chk("t2_wr_addr15",    32'(bus.wr_addr),  32'd15);
        send_byte(8'hAA);
        chk("t2_mem_full", 32'(bus.mem_full), 32'd1);
        chk("t2_wr_addr",  32'(bus.wr_addr),  32'd0);
        chk("t2_last",     32'(bus.last_byte), 32'hAA);
        for (int a = 0; a < 16; a++) rd(4'(a), a[0] ? 8'hAA : 8'hCC, "t2_mem");
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t2_overflow",  32'(bus.overflow),  32'd1);
        chk("t2_bc_held",   32'(bus.bit_count), 32'd0);
        chk("t2_full_held", 32'(bus.mem_full),  32'd1);
        chk("t2_wr_held",   32'(bus.wr_addr),   32'd0);
        chk("t2_last_held", 32'(bus.last_byte), 32'hAA);
        rd(4'd0, 8'hCC, "t2_mem0_kept");
        rd(4'd1, 8'hAA, "t2_mem1_kept");
        idle(3);
        chk("t2_overflow_sticky", 32'(bus.overflow), 32'd1);

        // 3: 0xA5 with random gaps
        do_clear(1);
        chk("t3_overflow_cleared", 32'(bus.overflow), 32'd0);
        chk("t3_full_cleared",     32'(bus.mem_full), 32'd0);
        p0 = pulses;
        v = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 3)));
            send_bit(v[i]);
        end
        idle(2);
        rd(4'd0, 8'hA5, "t3_rd0");
        chk("t3_pulses",  32'(pulses - p0),   32'd1);
        chk("t3_wr_addr", 32'(bus.wr_addr),   32'd1);

        // 4: partial byte discarded by clear
        do_clear(1);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("t4_bc5", 32'(bus.bit_count), 32'd5);
        do_clear(1);
        chk("t4_bc0", 32'(bus.bit_count), 32'd0);
        send_byte(8'h3C);
        rd(4'd0, 8'h3C, "t4_rd0");
        chk("t4_wr_addr", 32'(bus.wr_addr), 32'd1);
        chk("t4_last",    32'(bus.last_byte), 32'h3C);

        // 5: clear and bit_valid together
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        clear         = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.bit_valid = 1'b0;
        chk("t5_bc",      32'(bus.bit_count), 32'd0);
        chk("t5_wr_addr", 32'(bus.wr_addr),   32'd0);
        chk("t5_last",    32'(bus.last_byte), 32'd0);
        chk("t5_done",    32'(bus.byte_done), 32'd0);
        chk("t5_full",    32'(bus.mem_full),  32'd0);
        chk("t5_ovf",     32'(bus.overflow),  32'd0);
        idle(1);
        chk("t5_bc_after", 32'(bus.bit_count), 32'd0);

        // 6: read-during-write on address 1 (holds 0xAA from the fill)
        send_byte(8'h11);
        bus.rd_addr = 4'd1;
        v = 8'h5A;
        for (int i = 0; i < 7; i++) send_bit(v[i]);
        bus.bit_in    = v[7];
        bus.bit_valid = 1'b1;
        #1;
        chk("t6_before", 32'(bus.rd_data), 32'hAA);
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        chk("t6_after", 32'(bus.rd_data), 32'h5A);
        chk("t6_done",  32'(bus.byte_done), 32'd1);
        rd(4'd0, 8'h11, "t6_rd0");

        idle(1);
        chk("no_double_done", 32'(doubles), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
